peripheral_operand_collector: RTL and testbench

//  Parametrised operand-entry peripheral. Assembles NUM_OPS operands of DATA_W bits

---
 rtl/peripheral_operand_collector.sv | 131 +++++++++++++
 tb/tb_peripheral_operand_collector.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_operand_collector.sv
// Operand-entry peripheral: builds NUM_OPS operands of DATA_W bits from BYTE_W-bit
// entries. Slots are written either by explicit index or by an auto-increment
// pointer. Completion is flagged with a valid/ack handshake, and rejected writes
// set a sticky error.

// One BYTE_W entry slot register
module poc_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         we_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] slot_q;

    // Slot storage: cleared by reset/clear, loaded on a write select
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      slot_q <= '0;
        else if (clr_i) slot_q <= '0;
        else if (we_i)  slot_q <= d_i;
    end

    assign q_o = slot_q;
endmodule

module peripheral_operand_collector #(
    parameter  int BYTE_W  = 8,
    parameter  int DATA_W  = 32,
    parameter  int NUM_OPS = 2,
    localparam int SLOTS   = NUM_OPS * DATA_W / BYTE_W,
    localparam int IDX_W   = $clog2(SLOTS) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [BYTE_W-1:0]         inputdata,
    input  logic                      enterpulse,
    input  logic                      mode_i,
    input  logic [IDX_W-1:0]          index_i,
    input  logic                      clear_i,
    input  logic                      ack_i,
    output logic [NUM_OPS*DATA_W-1:0] operands_o,
    output logic                      ops_valid_o,
    output logic [IDX_W-1:0]          ptr_o,
    output logic                      err_o
);
    typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

    localparam logic [IDX_W-1:0] SLOTS_IDX = IDX_W'(SLOTS);

    state_t             state_q, state_d;
    logic [SLOTS-1:0]   mask_q, mask_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   slot_sel;
    logic [SLOTS-1:0]   wr_sel;
    logic               wr_en;
    logic               clr;

    // Target slot decode; pointer in auto mode, explicit index otherwise
    always_comb begin
        slot_sel = mode_i ? ptr_q : index_i;
        wr_sel   = '0;
        for (int k = 0; k < SLOTS; k++)
            wr_sel[k] = (slot_sel == IDX_W'(k));
    end

    // Next state: clear beats ack, ack (only in FULL) beats enter
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        ptr_d   = ptr_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        clr     = 1'b0;
        if (clear_i) begin
            clr     = 1'b1;
            state_d = IDLE;
            mask_d  = '0;
            ptr_d   = '0;
            err_d   = 1'b0;
        end else if (ack_i && state_q == FULL) begin
            state_d = IDLE;
            mask_d  = '0;
            ptr_d   = '0;
            if (enterpulse) err_d = 1'b1;
        end else if (enterpulse) begin
            // Out-of-range covers both bad index and a saturated pointer
            if (state_q == FULL || slot_sel >= SLOTS_IDX) begin
                err_d = 1'b1;
            end else begin
                wr_en   = 1'b1;
                mask_d  = mask_q | wr_sel;
                if (mode_i) ptr_d = ptr_q + IDX_W'(1);
                state_d = (&mask_d) ? FULL : COLLECT;
            end
        end
    end

    // Control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    for (genvar k = 0; k < SLOTS; k++) begin : g_slot
        poc_slot #(.W(BYTE_W)) u_slot (
            .clk   (clk),
            .reset (reset),
            .clr_i (clr),
            .we_i  (wr_en & wr_sel[k]),
            .d_i   (inputdata),
            .q_o   (operands_o[k*BYTE_W +: BYTE_W])
        );
    end

    assign ops_valid_o = (state_q == FULL);
    assign ptr_o       = ptr_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_peripheral_operand_collector.sv
// Scoreboard bench: the driver updates an array-based model and queues the expected
// outputs for each cycle, and a monitor pops the queue and compares after every edge.
module tb_peripheral_operand_collector;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  inputdata = '0;
    logic        enterpulse = 1'b0, mode_i = 1'b0, clear_i = 1'b0, ack_i = 1'b0;
    logic [3:0]  index_i = '0;
    logic [63:0] operands_o;
    logic        ops_valid_o, err_o;
    logic [3:0]  ptr_o;

    logic [3:0]  data6 = '0;
    logic        en6 = 1'b0;
    logic [4:0]  idx6 = '0;
    logic [63:0] operands6;
    logic        valid6, err6;
    logic [4:0]  ptr6;

    always #5 clk = ~clk;

    peripheral_operand_collector dut (
        .clk(clk), .reset(reset), .inputdata(inputdata), .enterpulse(enterpulse),
        .mode_i(mode_i), .index_i(index_i), .clear_i(clear_i), .ack_i(ack_i),
        .operands_o(operands_o), .ops_valid_o(ops_valid_o), .ptr_o(ptr_o), .err_o(err_o)
    );

    peripheral_operand_collector #(.BYTE_W(4), .DATA_W(16), .NUM_OPS(4)) dut6 (
        .clk(clk), .reset(reset), .inputdata(data6), .enterpulse(en6),
        .mode_i(1'b1), .index_i(idx6), .clear_i(1'b0), .ack_i(1'b0),
        .operands_o(operands6), .ops_valid_o(valid6), .ptr_o(ptr6), .err_o(err6)
    );

    typedef struct packed {
        logic [63:0] ops;
        logic        vld;
        logic [3:0]  ptr;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   nchk = 0;
    int   nerr = 0;

    // Reference model: byte store plus written flags
    logic [7:0] m_mem [8];
    bit         m_wr  [8];
    int         m_ptr;
    bit         m_err, m_full;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        for (int k = 0; k < 8; k++) e.ops[k*8 +: 8] = m_mem[k];
        e.vld = m_full;
        e.ptr = 4'(m_ptr);
        e.err = m_err;
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin m_mem[k] = '0; m_wr[k] = 0; end
        m_ptr = 0; m_err = 0; m_full = 0;
    endtask

    // One stimulus cycle: drive at negedge, update model, queue expected outputs
    task automatic step(input logic en, input logic md, input logic [3:0] idx,
                        input logic [7:0] d, input logic clr, input logic ak);
        int s, cnt;
        @(negedge clk);
        enterpulse = en; mode_i = md; index_i = idx; inputdata = d;
        clear_i = clr; ack_i = ak;
        if (clr) begin
            model_reset();
        end else if (ak && m_full) begin
            for (int k = 0; k < 8; k++) m_wr[k] = 0;
            m_ptr = 0; m_full = 0;
            if (en) m_err = 1;
        end else if (en) begin
            s = md ? m_ptr : int'(idx);
            if (m_full || s >= 8) m_err = 1;
            else begin
                m_mem[s] = d; m_wr[s] = 1;
                if (md) m_ptr++;
                cnt = 0;
                for (int k = 0; k < 8; k++) cnt += int'(m_wr[k]);
                if (cnt == 8) m_full = 1;
            end
        end
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    // Async reset between edges; outputs must drop without waiting for a clock
    task automatic async_reset();
        @(posedge clk); #3;
        reset = 1'b1;
        enterpulse = 0; clear_i = 0; ack_i = 0;
        model_reset();
        #1;
        chk("rst_ops", operands_o, 64'h0);
        chk("rst_vld", ops_valid_o, 0);
        chk("rst_ptr", ptr_o, 0);
        chk("rst_err", err_o, 0);
        @(negedge clk); reset = 1'b0;
    endtask

    // Monitor: compare DUT against queued expectation after each active edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ops", operands_o, e.ops);
                chk("valid", ops_valid_o, e.vld);
                chk("ptr", ptr_o, e.ptr);
                chk("err", err_o, e.err);
            end
        end
    end

    initial begin
        model_reset();
        #12;
        chk("init_ops", operands_o, 64'h0);
        chk("init_vld", ops_valid_o, 0);
        chk("init_err", err_o, 0);
        @(negedge clk); reset = 1'b0;

        // Auto mode, eight entries
        for (int k = 1; k <= 8; k++) step(1, 1, 0, 8'(k * 8'h11), 0, 0);
        idle(1);
        chk("t1_ops", operands_o, 64'h88776655_44332211);
        chk("t1_ptr", ptr_o, 4'd8);
        // Pulse while FULL is rejected, then ack releases
        step(1, 1, 0, 8'h99, 0, 0);
        idle(1);
        chk("t3_err", err_o, 1);
        step(0, 0, 0, 0, 0, 1);
        idle(1);
        chk("t3_ops_kept", operands_o, 64'h88776655_44332211);
        step(0, 0, 0, 0, 1, 0);
        // Refill, then ack + enter together
        for (int k = 0; k < 8; k++) step(1, 1, 0, 8'(k), 0, 0);
        step(1, 1, 0, 8'hEE, 0, 1);
        idle(1);
        chk("t3_ackwin_vld", ops_valid_o, 0);
        step(0, 0, 0, 0, 1, 0);

        // Indexed, reverse order with a rewrite of slot 3
        for (int k = 7; k >= 3; k--) step(1, 0, 4'(k), 8'(8'hA0 + k), 0, 0);
        step(1, 0, 4'd3, 8'h33, 0, 0);
        step(1, 0, 4'd3, 8'hA3, 0, 0);
        for (int k = 2; k >= 0; k--) step(1, 0, 4'(k), 8'(8'hA0 + k), 0, 0);
        idle(1);
        chk("t2_ops", operands_o, 64'hA7A6A5A4_A3A2A1A0);
        chk("t2_vld", ops_valid_o, 1);
        step(0, 0, 0, 0, 1, 0);

        // Out-of-range index
        step(1, 0, 4'd2, 8'h5A, 0, 0);
        step(1, 0, 4'd8, 8'hFF, 0, 0);
        idle(2);
        chk("t4_err", err_o, 1);
        chk("t4_ops", operands_o, 64'h00000000_005A0000);
        step(0, 0, 0, 0, 1, 0);

        // Reset mid-entry, then clear with a simultaneous pulse
        for (int k = 0; k < 3; k++) step(1, 1, 0, 8'(8'hC0 + k), 0, 0);
        async_reset();
        for (int k = 0; k < 3; k++) step(1, 1, 0, 8'(8'hD0 + k), 0, 0);
        step(1, 1, 0, 8'hEE, 1, 0);
        idle(1);
        chk("t5_ops", operands_o, 64'h0);

        // Randomised traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 9)), 8'($urandom),
                 ($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0));
        idle(2);

        // Narrow-entry configuration
        for (int k = 0; k < 16; k++) begin
            @(negedge clk); en6 = 1'b1; data6 = 4'(k);
            @(posedge clk); #1;
            chk("t6_valid", valid6, (k == 15));
        end
        @(negedge clk); en6 = 1'b0;
        chk("t6_op0", operands6[15:0], 16'h3210);
        chk("t6_op3", operands6[63:48], 16'hFEDC);
        chk("t6_ptr", ptr6, 5'd16);
        chk("t6_err", err6, 0);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            nchk++; nerr++;
            $display("FAIL drain: got %0d queued expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
